// File: rtl/fetch_redirect_ctrl.sv
// Front-end redirect sequencer: arbitrates redirect sources, holds a redirect
// while the icache refills, then issues a one-cycle flush with the target pc.
module fetch_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h1c000_000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic             exc_req,
  input  logic [31:0]      exc_pc,
  input  logic             mispred_req,
  input  logic [31:0]      mispred_pc,
  input  logic             bpu_req,
  input  logic [31:0]      bpu_pc,
  input  logic             icache_busy,
  input  logic             backend_stall,
  output logic [31:0]      new_pc,
  output logic [1:0]       fb_flush,
  output logic [1:0]       fb_pause,
  output logic             icache_cancel,
  output logic             redirect_busy,
  output logic [CNT_W-1:0] exc_cnt,
  output logic [CNT_W-1:0] mispred_cnt,
  output logic [CNT_W-1:0] bpu_cnt,
  output logic [CNT_W-1:0] wait_cnt
);

  localparam logic [1:0] SRC_EXC = 2'd0;
  localparam logic [1:0] SRC_MIS = 2'd1;
  localparam logic [1:0] SRC_BPU = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] tgt_pc, tgt_pc_next;
  logic [1:0]  tgt_src, tgt_src_next;
  logic        win_req;
  logic [1:0]  win_src;
  logic [31:0] win_pc;
  logic [1:0]  flush_next;

  // Fixed-priority arbitration: lower source id wins.
  always_comb begin
    win_req = exc_req | mispred_req | bpu_req;
    win_src = SRC_BPU;
    win_pc  = bpu_pc;
    if (exc_req) begin
      win_src = SRC_EXC;
      win_pc  = exc_pc;
    end else if (mispred_req) begin
      win_src = SRC_MIS;
      win_pc  = mispred_pc;
    end
  end

  // Next-state and latched-target logic.
  always_comb begin
    state_next   = IDLE;
    tgt_pc_next  = tgt_pc;
    tgt_src_next = tgt_src;
    case (state)
      WAIT: begin
        state_next = icache_busy ? WAIT : FLUSH;
        // Equal or higher priority replaces the held redirect.
        if (win_req && (win_src <= tgt_src)) begin
          tgt_pc_next  = win_pc;
          tgt_src_next = win_src;
        end
      end
      default: begin
        if (win_req) begin
          state_next   = icache_busy ? WAIT : FLUSH;
          tgt_pc_next  = win_pc;
          tgt_src_next = win_src;
        end
      end
    endcase
    flush_next = 2'b00;
    if (state_next == FLUSH) begin
      flush_next = (tgt_src_next == SRC_BPU) ? 2'b01 : 2'b11;
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state   <= IDLE;
      tgt_pc  <= RESET_PC;
      tgt_src <= SRC_BPU;
    end else begin
      state   <= state_next;
      tgt_pc  <= tgt_pc_next;
      tgt_src <= tgt_src_next;
    end
  end

  // Registered outputs, computed from the state being entered.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      new_pc        <= RESET_PC;
      fb_flush      <= 2'b00;
      icache_cancel <= 1'b0;
      redirect_busy <= 1'b0;
    end else begin
      fb_flush      <= flush_next;
      icache_cancel <= (state_next == WAIT);
      redirect_busy <= (state_next != IDLE);
      if (state_next == FLUSH) begin
        new_pc <= tgt_pc_next;
      end
    end
  end

  // Saturating performance counters; a redirect is counted as its flush ends.
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      exc_cnt     <= '0;
      mispred_cnt <= '0;
      bpu_cnt     <= '0;
      wait_cnt    <= '0;
    end else begin
      if (state == FLUSH) begin
        if (tgt_src == SRC_EXC && exc_cnt != '1) begin
          exc_cnt <= exc_cnt + CNT_W'(1);
        end
        if (tgt_src == SRC_MIS && mispred_cnt != '1) begin
          mispred_cnt <= mispred_cnt + CNT_W'(1);
        end
        if (tgt_src == SRC_BPU && bpu_cnt != '1) begin
          bpu_cnt <= bpu_cnt + CNT_W'(1);
        end
      end
      if (state == WAIT && wait_cnt != '1) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end

  assign fb_pause = {backend_stall, backend_stall | (state == WAIT)};

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Self-checking bench for fetch_redirect_ctrl: directed scenarios plus random
// redirect traffic compared against a cycle-level behavioural model.
module tb_fetch_redirect_ctrl;

  localparam int unsigned CNT_W  = 8;
  localparam int          SAT    = (1 << CNT_W) - 1;
  localparam logic [31:0] RST_PC = 32'h1c000000;

  logic             cpu_clk = 1'b0;
  logic             cpu_rst = 1'b0;
  logic             exc_req = 1'b0, mispred_req = 1'b0, bpu_req = 1'b0;
  logic [31:0]      exc_pc = '0, mispred_pc = '0, bpu_pc = '0;
  logic             icache_busy = 1'b0, backend_stall = 1'b0;
  logic [31:0]      new_pc;
  logic [1:0]       fb_flush, fb_pause;
  logic             icache_cancel, redirect_busy;
  logic [CNT_W-1:0] exc_cnt, mispred_cnt, bpu_cnt, wait_cnt;

  int total = 0;
  int bad   = 0;

  fetch_redirect_ctrl #(.RESET_PC(RST_PC), .CNT_W(CNT_W)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .exc_req(exc_req), .exc_pc(exc_pc),
    .mispred_req(mispred_req), .mispred_pc(mispred_pc),
    .bpu_req(bpu_req), .bpu_pc(bpu_pc),
    .icache_busy(icache_busy), .backend_stall(backend_stall),
    .new_pc(new_pc), .fb_flush(fb_flush), .fb_pause(fb_pause),
    .icache_cancel(icache_cancel), .redirect_busy(redirect_busy),
    .exc_cnt(exc_cnt), .mispred_cnt(mispred_cnt), .bpu_cnt(bpu_cnt),
    .wait_cnt(wait_cnt)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Model: a redirect is either held (waiting on the icache) or being flushed.
  bit          m_holding, m_flushing;
  int          m_src;
  logic [31:0] m_pc, m_new_pc;
  int          m_cnt[3];
  int          m_wcnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_holding = 0; m_flushing = 0; m_src = 2; m_pc = RST_PC; m_new_pc = RST_PC;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    m_wcnt = 0;
  endtask

  task automatic model_edge();
    bit          req;
    int          src;
    logic [31:0] pc;
    bit          go_flush, go_hold;
    req = 1; src = 2; pc = bpu_pc;
    if (exc_req) begin src = 0; pc = exc_pc; end
    else if (mispred_req) begin src = 1; pc = mispred_pc; end
    else if (!bpu_req) req = 0;
    if (m_flushing && m_cnt[m_src] < SAT) m_cnt[m_src]++;
    if (m_holding && m_wcnt < SAT) m_wcnt++;
    go_flush = 0; go_hold = 0;
    if (m_holding || req) begin
      if (req && (!m_holding || src <= m_src)) begin
        m_src = src; m_pc = pc;
      end
      go_flush = !icache_busy;
      go_hold  = icache_busy;
    end
    m_holding = go_hold; m_flushing = go_flush;
    if (go_flush) m_new_pc = m_pc;
  endtask

  task automatic check_all(input string tag);
    logic [1:0] ef, ep;
    ef = m_flushing ? ((m_src == 2) ? 2'b01 : 2'b11) : 2'b00;
    ep = {backend_stall, backend_stall | m_holding};
    chk({tag, ".new_pc"}, new_pc, m_new_pc);
    chk({tag, ".flush"}, 32'(fb_flush), 32'(ef));
    chk({tag, ".pause"}, 32'(fb_pause), 32'(ep));
    chk({tag, ".cancel"}, 32'(icache_cancel), 32'(m_holding));
    chk({tag, ".busy"}, 32'(redirect_busy), 32'(m_holding | m_flushing));
    chk({tag, ".exc_cnt"}, 32'(exc_cnt), 32'(m_cnt[0]));
    chk({tag, ".mis_cnt"}, 32'(mispred_cnt), 32'(m_cnt[1]));
    chk({tag, ".bpu_cnt"}, 32'(bpu_cnt), 32'(m_cnt[2]));
    chk({tag, ".wait_cnt"}, 32'(wait_cnt), 32'(m_wcnt));
  endtask

  task automatic set_in(input logic e, input logic [31:0] ep, input logic m,
                        input logic [31:0] mp, input logic b, input logic [31:0] bp,
                        input logic busy, input logic stall);
    exc_req = e; exc_pc = ep; mispred_req = m; mispred_pc = mp;
    bpu_req = b; bpu_pc = bp; icache_busy = busy; backend_stall = stall;
  endtask

  task automatic step(input string tag);
    @(posedge cpu_clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  localparam logic [31:0] PA = 32'h1c000a00, PB = 32'h1c000b00, PC = 32'h1c000c00;

  initial begin
    model_reset();
    #1 cpu_rst = 1'b1;
    #1;
    chk("rst.new_pc", new_pc, 32'h1c000000);
    chk("rst.flush", 32'(fb_flush), 32'd0);
    chk("rst.mis_cnt", 32'(mispred_cnt), 32'd0);
    backend_stall = 1'b1;
    #1;
    chk("rst.pause", 32'(fb_pause), 32'd3);
    backend_stall = 1'b0;
    #19 cpu_rst = 1'b0;
    step("idle");

    // Single mispredict, icache idle.
    set_in(0, 0, 1, 32'h1c000100, 0, 0, 0, 0);
    step("mis");
    chk("mis.flush11", 32'(fb_flush), 32'd3);
    chk("mis.target", new_pc, 32'h1c000100);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step("mis2");
    chk("mis.flush00", 32'(fb_flush), 32'd0);
    chk("mis.count", 32'(mispred_cnt), 32'd1);

    // Three simultaneous requests: exception wins.
    set_in(1, PA, 1, PB, 1, PC, 0, 0);
    step("tri");
    chk("tri.target", new_pc, PA);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step("tri2");
    chk("tri.exc_cnt", 32'(exc_cnt), 32'd1);
    chk("tri.bpu_cnt", 32'(bpu_cnt), 32'd0);

    // BPU redirect held by icache, then overridden by an exception.
    set_in(0, 0, 0, 0, 1, PC, 1, 0);
    step("w0");
    chk("wait.cancel", 32'(icache_cancel), 32'd1);
    chk("wait.pause0", 32'(fb_pause[0]), 32'd1);
    set_in(1, PA, 0, 0, 0, 0, 1, 0);
    step("w1");
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    step("w2");
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step("w3");
    chk("wait.target", new_pc, PA);
    chk("wait.flush", 32'(fb_flush), 32'd3);
    chk("wait.wait_cnt", 32'(wait_cnt), 32'd3);
    step("w4");
    chk("wait.bpu_cnt", 32'(bpu_cnt), 32'd0);

    // BPU redirect under backend stall: partial flush, pause untouched.
    set_in(0, 0, 0, 0, 1, 32'h1c000040, 0, 1);
    step("bst");
    chk("bst.flush01", 32'(fb_flush), 32'd1);
    chk("bst.target", new_pc, 32'h1c000040);
    chk("bst.pause", 32'(fb_pause), 32'd3);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step("bst2");

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      set_in($urandom_range(0, 5) == 0, $urandom,
             $urandom_range(0, 3) == 0, $urandom,
             $urandom_range(0, 2) == 0, $urandom,
             $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3);
      step("rnd");
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("drain");

    // Back-to-back mispredicts drive the counter into saturation.
    for (int i = 0; i < (1 << CNT_W) + 2; i++) begin
      set_in(0, 0, 1, 32'h1c000000 + 32'(i * 4), 0, 0, 0, 0);
      step("sat");
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step("sat_end");
    step("sat_hold");
    chk("sat.mis_cnt", 32'(mispred_cnt), 32'(SAT));

    // Reset in the middle of WAIT drops the held redirect.
    set_in(0, 0, 0, 0, 1, PB, 1, 0);
    step("rw0");
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #3 cpu_rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_mid");
    chk("rst_mid.cancel", 32'(icache_cancel), 32'd0);
    chk("rst_mid.new_pc", new_pc, RST_PC);
    @(posedge cpu_clk);
    #2 cpu_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step("post_rst");
      chk("post_rst.noflush", 32'(fb_flush), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
# fetch_redirect_ctrl

Front-end redirect sequencer between the backend/BPU redirect sources and the fetch datapath (pc register, BPU, instbuffer, icache). It arbitrates simultaneous redirect requests by priority and holds a redirect while the icache has a refill outstanding. It issues a one-cycle flush with the redirect target to the pc and instbuffer, and keeps saturating per-source redirect counters for performance analysis.

## Interface
Parameters:
- RESET_PC, 32'h1c000_000, value of `new_pc` after reset.
- CNT_W, 16, width of each performance counter.

Ports:
- cpu_clk  in  1  single clock; all state updates on the rising edge
- cpu_rst  in  1  reset, asynchronous, active-high
- exc_req  in  1  exception/ertn redirect request (priority 0, highest)
- exc_pc  in  32  exception target
- mispred_req  in  1  ex-stage branch mispredict redirect (priority 1)
- mispred_pc  in  32  mispredict correct target
- bpu_req  in  1  BPU predicted-taken redirect (priority 2, lowest)
- bpu_pc  in  32  BPU predicted target
- icache_busy  in  1  icache refill outstanding; a redirect must not be issued while this is high
- backend_stall  in  1  instbuffer/backend back-pressure
- new_pc  out  32  redirect target; valid while `fb_flush[0]`=1
- fb_flush  out  2  bit0 flushes pc/BPU; bit1 flushes instbuffer
- fb_pause  out  2  bit0 pauses pc; bit1 pauses instbuffer
- icache_cancel  out  1  asks the icache to drop the in-flight fetch result
- redirect_busy  out  1  1 while in WAIT or FLUSH
- exc_cnt, mispred_cnt, bpu_cnt  out  CNT_W each  saturating redirect counts, one per source
- wait_cnt  out  CNT_W  saturating count of cycles spent in WAIT

## Operation
- States: IDLE, WAIT, FLUSH. The state is encoded in a register.
- Arbitration each cycle over the valid requests: exc > mispred > bpu. The winner's target and source id are latched into `tgt_pc` and `tgt_src`.
- IDLE or FLUSH with any request present:
  - If `icache_busy`=0, go to FLUSH.
  - Otherwise go to WAIT, with `icache_cancel`=1 registered.
- IDLE or FLUSH with no request: go to IDLE.
- WAIT:
  - `icache_cancel` stays 1 and `wait_cnt` increments each cycle.
  - A new request whose priority is equal to or higher than `tgt_src` overwrites the latched target and source. A lower-priority request is dropped.
  - When `icache_busy`=0, go to FLUSH.
- FLUSH lasts one cycle:
  - `new_pc`=`tgt_pc`.
  - `fb_flush` is 2'b11 for exc or mispred, and 2'b01 for bpu. A bpu redirect keeps the instbuffer contents.
  - The counter for `tgt_src` increments.
  - Requests arriving in FLUSH are treated as in IDLE, so back-to-back redirects are possible.
- `fb_pause` is combinational: bit0 = backend_stall | (state==WAIT); bit1 = backend_stall.
- A redirect is never lost to `backend_stall`: flush overrides pause.
- Counters saturate at all-ones and never wrap.
- `new_pc` holds its last value outside FLUSH.

## Timing
- Reset, asynchronous, takes effect immediately:
  - state=IDLE, `new_pc`=RESET_PC, `fb_flush`=0, `icache_cancel`=0, `redirect_busy`=0.
  - All counters are 0.
  - `fb_pause` follows `backend_stall`.
- Latency:
  - Request in cycle N with `icache_busy`=0: FLUSH in N+1, with `fb_flush`/`new_pc` valid for exactly cycle N+1.
  - Request in cycle N with `icache_busy`=1: WAIT from N+1. FLUSH occurs one cycle after the first cycle in which `icache_busy`=0 is sampled.
- Requests are single-cycle pulses. The block does not require a request to be held.
- Simultaneous requests: only the winner is served; losers are dropped. The mispredict and exception sources re-raise via the backend flush.
- A reset asserted mid-WAIT or mid-FLUSH discards the latched target; no flush is issued after the reset is released.

## Test plan
- Reset, then IDLE with no requests:
  - `new_pc`=32'h1c000000, `fb_flush`=00, all counters 0.
  - `backend_stall`=1 gives `fb_pause`=11.
- `mispred_req` with `mispred_pc`=32'h1c000100, `icache_busy`=0, cycle N: cycle N+1 has `fb_flush`=11 and `new_pc`=32'h1c000100; cycle N+2 has `fb_flush`=00 and `mispred_cnt`=1.
- `exc_req`, `mispred_req` and `bpu_req` together (targets A/B/C), `icache_busy`=0: one FLUSH with `new_pc`=A; `exc_cnt`=1, other counters 0.
- `bpu_req`=C while `icache_busy`=1 for 3 cycles, then `exc_req`=A during WAIT:
  - `icache_cancel`=1 and `fb_pause[0]`=1 during WAIT.
  - FLUSH with `new_pc`=A, `fb_flush`=11.
  - `wait_cnt`=3, `bpu_cnt`=0.
- `bpu_req` with `bpu_pc`=32'h1c000040, `icache_busy`=0, `backend_stall`=1: `fb_flush`=01 and `new_pc`=32'h1c000040; `fb_pause`=11 is unaffected.
- Force `mispred_cnt` to saturation via 2^CNT_W+2 requests: it holds at all-ones. Assert `cpu_rst` mid-WAIT: outputs immediately take their reset values and no FLUSH follows.
